// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//
// UART receive stage. Turns the asynchronous serial line into bytes for the
// multiplier control FSM. The frame format is 8N1, LSB first. One of four
// bit periods is chosen at runtime by freq_control.
//
// Ports
//   clk                 system clock (single domain)
//   reset               asynchronous, active-low reset
//   uart_rx_d_in        raw serial line, idle high, asynchronous to clk
//   freq_control[1:0]   baud select; sampled only when a frame starts
//   uart_received_data  last correctly framed byte; held between frames
//   uart_rx_valid       level flag, high once a good byte is available,
//                       cleared when the next start bit is accepted
//   framing_error       most recent frame ended with a low stop bit
//   rx_busy             high from the start edge until the return to IDLE
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT_0 = 1042,
    parameter int CLKS_PER_BIT_1 = 521,
    parameter int CLKS_PER_BIT_2 = 174,
    parameter int CLKS_PER_BIT_3 = 87,
    parameter int CNT_W          = $clog2(CLKS_PER_BIT_0 + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx_d_in,
    input  logic [1:0] freq_control,
    output logic [7:0] uart_received_data,
    output logic       uart_rx_valid,
    output logic       framing_error,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] N0  = CNT_W'(CLKS_PER_BIT_0);
    localparam logic [CNT_W-1:0] N1  = CNT_W'(CLKS_PER_BIT_1);
    localparam logic [CNT_W-1:0] N2  = CNT_W'(CLKS_PER_BIT_2);
    localparam logic [CNT_W-1:0] N3  = CNT_W'(CLKS_PER_BIT_3);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic             rx_m;       // first synchronizer flop
    logic             rx_s;       // second synchronizer flop; only this one is used
    logic [CNT_W-1:0] cnt;        // bit-timing down-counter
    logic [CNT_W-1:0] n_lat;      // divisor latched for the current frame
    logic [CNT_W-1:0] n_sel;      // divisor selected by freq_control right now
    logic [CNT_W-1:0] half_m1;    // floor(n_sel/2) - 1, the start-bit reload value
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer. Both flops reset to the idle-line level, so the
    // first cycle after reset cannot look like a start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx_d_in;
            rx_s <= rx_m;
        end
    end

    // -----------------------------------------------------------------------
    // Divisor select. This value is consumed only on the IDLE->START edge.
    // That means a change to freq_control in mid-frame has no effect until
    // the next frame begins.
    // -----------------------------------------------------------------------
    always_comb begin
        n_sel = N3;
        unique case (freq_control)
            2'b00:   n_sel = N0;
            2'b01:   n_sel = N1;
            2'b10:   n_sel = N2;
            default: n_sel = N3;
        endcase
        half_m1 = (n_sel >> 1) - ONE;
    end

    // -----------------------------------------------------------------------
    // Receive FSM.
    // The counter is loaded with (period - 1). A sample is taken on the cycle
    // the counter reads zero. The first sample therefore lands exactly
    // floor(N/2) clocks after the edge that saw the start bit, and each later
    // sample lands N clocks after the one before it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            n_lat              <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
            uart_received_data <= 8'h00;
            uart_rx_valid      <= 1'b0;
            framing_error      <= 1'b0;
            rx_busy            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        n_lat   <= n_sel;
                        cnt     <= half_m1;
                        bit_idx <= '0;
                        rx_busy <= 1'b1;
                        state   <= START;
                    end
                end

                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (!rx_s) begin
                        // Start bit confirmed at mid-bit. The previous result
                        // is now stale from the consumer's point of view.
                        uart_rx_valid <= 1'b0;
                        framing_error <= 1'b0;
                        cnt           <= n_lat - ONE;
                        state         <= DATA;
                    end else begin
                        // Line was high again at mid-bit: treat it as a glitch
                        // and leave the outputs exactly as they were.
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end

                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        shreg <= {rx_s, shreg[7:1]};   // LSB arrives first
                        cnt   <= n_lat - ONE;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (rx_s) begin
                        uart_received_data <= shreg;
                        uart_rx_valid      <= 1'b1;
                        rx_busy            <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        // Bad stop bit. Keep the previous byte and leave valid
                        // low. Do not re-arm until the line returns high, or
                        // a held break would be read as a stream of 0x00 frames.
                        framing_error <= 1'b1;
                        state         <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    rx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed scenarios followed by randomized frames. Each frame is checked
// against a simple byte-level model of what the receiver should present:
// the last good byte, the valid level, the framing error, and the pin-to-valid
// latency computed as N/2 + 9N + 1 + 2.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int N0 = 32;
    localparam int N1 = 24;
    localparam int N2 = 20;
    localparam int N3 = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [1:0] fc    = 2'b11;
    logic [7:0] uart_received_data;
    logic       uart_rx_valid;
    logic       framing_error;
    logic       rx_busy;

    uart_rx_deserializer #(
        .CLKS_PER_BIT_0(N0),
        .CLKS_PER_BIT_1(N1),
        .CLKS_PER_BIT_2(N2),
        .CLKS_PER_BIT_3(N3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rx_d_in      (rx),
        .freq_control      (fc),
        .uart_received_data(uart_received_data),
        .uart_rx_valid     (uart_rx_valid),
        .framing_error     (framing_error),
        .rx_busy           (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: behaves like an edge-detecting consumer of uart_rx_valid.
    logic v_q      = 1'b0;
    int   rise_cyc = 0;
    int   rise_cnt = 0;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        if (uart_rx_valid && !v_q) begin
            rise_cyc = cyc;
            rise_cnt = rise_cnt + 1;
        end
        v_q = uart_rx_valid;
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int t_fall = 0;

    // Expected-state model
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_fe    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic int nval(input logic [1:0] f);
        case (f)
            2'b00:   return N0;
            2'b01:   return N1;
            2'b10:   return N2;
            default: return N3;
        endcase
    endfunction

    // Drives one frame with n clocks per bit. The frame starts at #1 after a
    // clock edge. If sw_bit matches a data-bit index, freq_control is changed
    // to sw_val during that bit. If rst_bit matches a data-bit index, reset is
    // asserted halfway through that bit and the task returns at once.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int n,
                              input int sw_bit, input logic [1:0] sw_val,
                              input int rst_bit);
        rx     = 1'b0;
        t_fall = cyc;
        wait_clks(n);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == sw_bit) fc = sw_val;
            if (i == rst_bit) begin
                wait_clks(n / 2);
                reset = 1'b0;
                return;
            end
            wait_clks(n);
        end
        rx = stop;
        wait_clks(n);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"},  {24'h0, uart_received_data}, {24'h0, exp_data});
        chk({tag, "_valid"}, {31'h0, uart_rx_valid},      {31'h0, exp_valid});
        chk({tag, "_fe"},    {31'h0, framing_error},      {31'h0, exp_fe});
    endtask

    task automatic chk_latency(input string tag, input int n);
        chk(tag, rise_cyc - t_fall, n / 2 + 9 * n + 1 + 2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},  {24'h0, uart_received_data}, 32'h0);
        chk({tag, "_valid"}, {31'h0, uart_rx_valid},      32'h0);
        chk({tag, "_fe"},    {31'h0, framing_error},      32'h0);
        chk({tag, "_busy"},  {31'h0, rx_busy},            32'h0);
    endtask

    initial begin
        int r0;
        int b0;
        logic [7:0] rb;
        logic       good;
        int         n;

        // Reset state
        #1;
        chk_reset_vals("reset");
        wait_clks(3);
        reset = 1'b1;
        wait_clks(3);
        chk("idle_busy", {31'h0, rx_busy}, 32'h0);

        // Single byte at N=16
        fc = 2'b11;
        wait_clks(1);
        send_frame(8'hA5, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'hA5; exp_valid = 1'b1; exp_fe = 1'b0;
        chk_model("single");
        chk_latency("single_lat", N3);
        chk("single_busy", {31'h0, rx_busy}, 32'h0);

        // Back-to-back with no idle gap
        wait_clks(4);
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'h3C;
        chk_model("b2b_first");
        send_frame(8'hC3, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'hC3;
        chk_model("b2b_second");
        chk_latency("b2b_lat", N3);
        chk("b2b_edges", rise_cnt - r0, 2);

        // Start-bit glitch of 3 clocks
        wait_clks(4);
        b0 = busy_cnt;
        r0 = rise_cnt;
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(20);
        chk("glitch_busy_pulsed", {31'h0, (busy_cnt > b0)}, 32'h1);
        chk("glitch_busy_now", {31'h0, rx_busy}, 32'h0);
        chk("glitch_no_edge", rise_cnt - r0, 0);
        chk_model("glitch");

        // Framing error followed by a held break
        send_frame(8'h55, 1'b0, N3, -1, 2'b00, -1);
        wait_clks(40);
        exp_valid = 1'b0; exp_fe = 1'b1;
        chk_model("ferr");
        chk("ferr_busy_held", {31'h0, rx_busy}, 32'h1);
        rx = 1'b1;
        wait_clks(4);
        chk("ferr_busy_release", {31'h0, rx_busy}, 32'h0);
        send_frame(8'h12, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'h12; exp_valid = 1'b1; exp_fe = 1'b0;
        chk_model("after_ferr");

        // Baud switch in mid-frame: the frame keeps N=32
        wait_clks(2);
        fc = 2'b00;
        wait_clks(2);
        send_frame(8'h81, 1'b1, N0, 3, 2'b11, -1);
        exp_data = 8'h81;
        chk_model("baud_sw");
        chk_latency("baud_sw_lat", N0);
        wait_clks(2);
        send_frame(8'h5A, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'h5A;
        chk_model("baud_next");
        chk_latency("baud_next_lat", N3);

        // Reset asserted during data bit 4
        wait_clks(3);
        send_frame(8'hF0, 1'b1, N3, -1, 2'b00, 4);
        #1;
        chk_reset_vals("midrst");
        rx = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        exp_data = 8'h00; exp_valid = 1'b0; exp_fe = 1'b0;
        wait_clks(3);
        send_frame(8'h7E, 1'b1, N3, -1, 2'b00, -1);
        exp_data = 8'h7E; exp_valid = 1'b1;
        chk_model("post_rst");

        // Randomized frames: random rate, random byte, some bad stop bits
        for (int k = 0; k < 14; k++) begin
            fc = 2'($urandom_range(0, 3));
            wait_clks(1);
            n    = nval(fc);
            rb   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(rb, good, n, -1, 2'b00, -1);
            if (good) begin
                exp_data = rb; exp_valid = 1'b1; exp_fe = 1'b0;
                chk_model("rand_good");
                chk_latency("rand_lat", n);
            end else begin
                exp_valid = 1'b0; exp_fe = 1'b1;
                wait_clks(n);
                chk_model("rand_bad");
                chk("rand_bad_busy", {31'h0, rx_busy}, 32'h1);
                rx = 1'b1;
            end
            wait_clks(2 + $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
